// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared constants and helpers for the pipelined ripple-carry adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   chunk_width()                  : bits resolved per pipeline stage
//   config_ok()                    : legality of a WIDTH/STAGES pair, used by
//                                    the top level to stop elaboration early
//   Optional feature macro: PIPELINED_ADDER_OVF_EN (signed-overflow flag).
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit config_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if
//   Valid/ready operand and result bundle for pipelined_adder.
//   in_valid/in_ready  : operand handshake (in1, in2, cin)
//   out_valid/out_ready: result handshake (sum, cout, ovf)
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side
//   ovf exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , ovf
`endif
    );

endinterface

// File: rtl/adder_chunk.sv
// adder_chunk
//   Combinational CHUNK-bit adder slice with carry-in and carry-out.
//   a_i, b_i : operand slices
//   ci_i     : carry into bit 0 of the slice
//   sum_o    : slice sum
//   co_o     : carry out of the slice MSB
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o
);

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder split into STAGES chunks, one chunk resolved per clock,
//   with valid/ready flow control and a single global advance/stall.
//   clk    : rising-edge clock
//   resetb : asynchronous active-low reset, clears valid, data and carry
//   bus    : pipelined_adder_if slave (operands in, registered result out)
//   Optional: PIPELINED_ADDER_OVF_EN adds a registered signed-overflow flag.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             resetb,
    pipelined_adder_if.slave bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!config_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Stage k register: sum chunks 0..k, carry out of chunk k, and the
    // operands still to be added (chunks k+1..) skewed forward unchanged.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];

    logic [CHUNK-1:0] op_a      [STAGES];
    logic [CHUNK-1:0] op_b      [STAGES];
    logic             op_ci     [STAGES];
    logic [CHUNK-1:0] chunk_sum [STAGES];
    logic             chunk_co  [STAGES];

    logic adv;

    // One advance signal for the whole pipe: bubbles are never collapsed,
    // so a stall freezes every stage including its valid bit.
    assign adv          = !valid_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign op_a[k]  = bus.in1[CHUNK-1:0];
            assign op_b[k]  = bus.in2[CHUNK-1:0];
            assign op_ci[k] = bus.cin;
        end else begin : g_next
            assign op_a[k]  = a_q[k-1][k*CHUNK +: CHUNK];
            assign op_b[k]  = b_q[k-1][k*CHUNK +: CHUNK];
            assign op_ci[k] = carry_q[k-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i   (op_a[k]),
            .b_i   (op_b[k]),
            .ci_i  (op_ci[k]),
            .sum_o (chunk_sum[k]),
            .co_o  (chunk_co[k])
        );
    end

    always_comb begin
        valid_d[0]            = bus.in_valid;
        a_d[0]                = bus.in1;
        b_d[0]                = bus.in2;
        sum_d[0]              = '0;
        sum_d[0][CHUNK-1:0]   = chunk_sum[0];
        carry_d[0]            = chunk_co[0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k]                  = valid_q[k-1];
            a_d[k]                      = a_q[k-1];
            b_d[k]                      = b_q[k-1];
            sum_d[k]                    = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK]  = chunk_sum[k];
            carry_d[k]                  = chunk_co[k];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                carry_q[k] <= carry_d[k];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_EN
    // The operand MSBs live in the top chunk, which is still in the skew
    // registers when the last stage resolves it, so no extra flops are needed.
    logic a_msb;
    logic b_msb;
    logic ovf_d;
    logic ovf_q;

    assign a_msb = op_a[STAGES-1][CHUNK-1];
    assign b_msb = op_b[STAGES-1][CHUNK-1];
    assign ovf_d = (a_msb == b_msb) && (chunk_sum[STAGES-1][CHUNK-1] != a_msb);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Directed checks on a WIDTH=16/STAGES=4 adder plus scoreboarded random
//   traffic shared with STAGES=1 and STAGES=16 instances.
//   Honours PIPELINED_ADDER_OVF_EN when defined.
module tb_pipelined_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetb = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) if4  ();
    pipelined_adder_if #(.WIDTH(W)) if1  ();
    pipelined_adder_if #(.WIDTH(W)) if16 ();

    assign if4.in_valid  = in_valid;
    assign if4.in1       = in1;
    assign if4.in2       = in2;
    assign if4.cin       = cin;
    assign if4.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in1       = in1;
    assign if1.in2       = in2;
    assign if1.cin       = cin;
    assign if1.out_ready = out_ready;
    assign if16.in_valid  = in_valid;
    assign if16.in1       = in1;
    assign if16.in2       = in2;
    assign if16.cin       = cin;
    assign if16.out_ready = out_ready;

    pipelined_adder #(.WIDTH(W), .STAGES(4))  u_dut4  (.clk(clk), .resetb(resetb), .bus(if4.slave));
    pipelined_adder #(.WIDTH(W), .STAGES(1))  u_dut1  (.clk(clk), .resetb(resetb), .bus(if1.slave));
    pipelined_adder #(.WIDTH(W), .STAGES(16)) u_dut16 (.clk(clk), .resetb(resetb), .bus(if16.slave));

    logic ovf4, ovf1, ovf16;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf4  = if4.ovf;
    assign ovf1  = if1.ovf;
    assign ovf16 = if16.ovf;
`else
    assign ovf4  = 1'b0;
    assign ovf1  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from a flat full-width add.
    function automatic logic [17:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
        logic [W:0] s;
        logic       o;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef PIPELINED_ADDER_OVF_EN
        o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
        o = 1'b0;
`endif
        return {o, s};
    endfunction

    // Scoreboards: record accepted operands, compare each delivered result.
    logic [17:0] q4[$];
    logic [17:0] q1[$];
    logic [17:0] q16[$];

    always @(negedge clk) begin : mon4
        logic [17:0] e;
        if (!resetb) q4.delete();
        else begin
            if (if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) check("s4_spurious", 64'(1), 64'(0));
                else begin
                    e = q4.pop_front();
                    check("s4_result", 64'({ovf4, if4.cout, if4.sum}), 64'(e));
                end
            end
            if (if4.in_valid && if4.in_ready) q4.push_back(ref_add(if4.in1, if4.in2, if4.cin));
        end
    end

    always @(negedge clk) begin : mon1
        logic [17:0] e;
        if (!resetb) q1.delete();
        else begin
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) check("s1_spurious", 64'(1), 64'(0));
                else begin
                    e = q1.pop_front();
                    check("s1_result", 64'({ovf1, if1.cout, if1.sum}), 64'(e));
                end
            end
            if (if1.in_valid && if1.in_ready) q1.push_back(ref_add(if1.in1, if1.in2, if1.cin));
        end
    end

    always @(negedge clk) begin : mon16
        logic [17:0] e;
        if (!resetb) q16.delete();
        else begin
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) check("s16_spurious", 64'(1), 64'(0));
                else begin
                    e = q16.pop_front();
                    check("s16_result", 64'({ovf16, if16.cout, if16.sum}), 64'(e));
                end
            end
            if (if16.in_valid && if16.in_ready) q16.push_back(ref_add(if16.in1, if16.in2, if16.cin));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Single operand through the STAGES=4 pipe with explicit latency checks.
    task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        in_valid = 1'b1; in1 = a; in2 = b; cin = c; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_early_valid"}, 64'(if4.out_valid), 64'(0));
            cycle();
        end
        check({tag, "_valid"}, 64'(if4.out_valid), 64'(1));
        check({tag, "_sum"},   64'(if4.sum),       64'(es));
        check({tag, "_cout"},  64'(if4.cout),      64'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
        check({tag, "_ovf"},   64'(ovf4),          64'(eo));
`else
        if (eo) n_checks += 0;
`endif
    endtask

    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W-1:0] vs [4];
    logic         vo [4];

    initial begin
        // Reset state
        #2 resetb = 1'b0;
        #1;
        check("rst_out_valid", 64'(if4.out_valid), 64'(0));
        check("rst_sum",       64'(if4.sum),       64'(0));
        check("rst_cout",      64'(if4.cout),      64'(0));
        check("rst_ovf",       64'(ovf4),          64'(0));
        check("rst_in_ready",  64'(if4.in_ready),  64'(1));
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        cycle();

        // Carry ripples through all four chunks
        send_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Signed overflow boundary
        send_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Back-to-back stream
        va = '{16'h1234, 16'h00FF, 16'h8000, 16'h0000};
        vb = '{16'h1111, 16'h0001, 16'h8000, 16'h0000};
        vc = '{1'b0,     1'b1,     1'b0,     1'b0};
        vs = '{16'h2345, 16'h0101, 16'h0000, 16'h0000};
        vo = '{1'b0,     1'b0,     1'b1,     1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in1 = va[i]; in2 = vb[i]; cin = vc[i];
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("b2b_valid", 64'(if4.out_valid), 64'(1));
            check("b2b_sum",   64'(if4.sum),       64'(vs[i]));
            check("b2b_cout",  64'(if4.cout),      64'(vo[i]));
        end

        // Stall with four results in flight
        va = '{16'h0001, 16'hABCD, 16'hF000, 16'h5555};
        vb = '{16'h0002, 16'h1234, 16'h1000, 16'hAAAA};
        vc = '{1'b0,     1'b0,     1'b1,     1'b1};
        vs = '{16'h0003, 16'hBE01, 16'h0001, 16'h0000};
        vo = '{1'b0,     1'b0,     1'b1,     1'b1};
        cycle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in1 = va[i]; in2 = vb[i]; cin = vc[i];
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready",  64'(if4.in_ready),  64'(0));
            check("stall_out_valid", 64'(if4.out_valid), 64'(1));
            check("stall_sum",       64'(if4.sum),       64'(vs[0]));
            cycle();
        end
        check("stall_sum_end", 64'(if4.sum), 64'(vs[0]));
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 64'(if4.in_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 64'(if4.out_valid), 64'(1));
            check("drain_sum",   64'(if4.sum),       64'(vs[i]));
            check("drain_cout",  64'(if4.cout),      64'(vo[i]));
            cycle();
        end
        check("drain_empty", 64'(if4.out_valid), 64'(0));

        // Reset while results are in flight
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in1 = 16'h1234; in2 = 16'h1111; cin = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        check("pre_rst_sum", 64'(if4.sum), 64'(16'h2345));
        resetb = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(if4.out_valid), 64'(0));
        check("mid_rst_sum",       64'(if4.sum),       64'(0));
        check("mid_rst_cout",      64'(if4.cout),      64'(0));
        check("mid_rst_in_ready",  64'(if4.in_ready),  64'(1));
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("post_rst_no_stale", 64'(if4.out_valid), 64'(0));
        end

        // Random traffic, scoreboarded on all three depths
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in1       = 16'($urandom);
            in2       = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (24) cycle();
        check("s4_leftover",  64'(q4.size()),  64'(0));
        check("s1_leftover",  64'(q1.size()),  64'(0));
        check("s16_leftover", 64'(q16.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
